// File: rtl/ground_scroller_if.sv
// ground_scroller_if: pixel-position/game-state bundle and ground outputs.
// master drives h_cnt, v_cnt, state, new_frame; slave returns black_ground, scroll_pos, speed.
interface ground_scroller_if #(
   parameter int SPD_W = 4
);
   logic [9:0]       h_cnt;
   logic [9:0]       v_cnt;
   logic [1:0]       state;
   logic             new_frame;
   logic             black_ground;
   logic [9:0]       scroll_pos;
   logic [SPD_W-1:0] speed;

   modport master (
      output h_cnt, v_cnt, state, new_frame,
      input  black_ground, scroll_pos, speed
   );

   modport slave (
      input  h_cnt, v_cnt, state, new_frame,
      output black_ground, scroll_pos, speed
   );
endinterface

// File: rtl/ground_scroller.sv
// ground_scroller: scrolling ground band renderer with per-frame speed ramp.
// Ports: clk, rst (sync, active-high), gs (slave: counters/state in, pixel/pos/speed out).
// Optional ramp enabled by defining GROUND_SPEED_RAMP_EN; otherwise speed is fixed.
module ground_scroller #(
   parameter int PAT_W       = 160,
   parameter int PAT_H       = 8,
   parameter int GROUND_Y    = 400,
   parameter int H_ACTIVE    = 640,
   parameter int SPEED_INIT  = 6,
   parameter int SPEED_MAX   = 12,
   parameter int RAMP_FRAMES = 600,
   parameter int SPD_W       = 4
) (
   input logic         clk,
   input logic         rst,
   ground_scroller_if.slave gs
);

   logic             adv;
   logic [SPD_W-1:0] spd_cur;
   logic [10:0]      t;
   logic [9:0]       pos_q, pos_d;

   assign adv = gs.new_frame &
                ((gs.state == 2'b01) | (gs.state == 2'b10));

`ifdef GROUND_SPEED_RAMP_EN
   localparam int RW = (RAMP_FRAMES > 1) ?
                       $clog2(RAMP_FRAMES) : 1;

   typedef enum logic [1:0] {
      STOP,
      PLAY,
      HALT
   } mode_e;

   mode_e            mode;
   logic [SPD_W-1:0] spd_q, spd_d;
   logic [RW-1:0]    ramp_q, ramp_d;

   always_comb begin
      mode = HALT;
      unique case (gs.state)
         2'b00:        mode = STOP;
         2'b01, 2'b10: mode = PLAY;
         default:      mode = HALT;
      endcase
   end

   always_comb begin
      spd_d  = spd_q;
      ramp_d = ramp_q;
      unique case (mode)
         STOP: begin
            spd_d  = SPD_W'(SPEED_INIT);
            ramp_d = '0;
         end
         PLAY: begin
            if (gs.new_frame) begin
               if (ramp_q == RW'(RAMP_FRAMES - 1)) begin
                  ramp_d = '0;
                  if (spd_q < SPD_W'(SPEED_MAX))
                     spd_d = spd_q + SPD_W'(1);
               end else begin
                  ramp_d = ramp_q + RW'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         spd_q  <= SPD_W'(SPEED_INIT);
         ramp_q <= '0;
      end else begin
         spd_q  <= spd_d;
         ramp_q <= ramp_d;
      end
   end

   // position step uses the pre-increment speed
   assign spd_cur = spd_q;
`else
   assign spd_cur = SPD_W'(SPEED_INIT);
`endif

   always_comb begin
      t     = {1'b0, pos_q} + 11'(spd_cur);
      pos_d = pos_q;
      if (adv) begin
         if (t >= 11'(PAT_W))
            pos_d = 10'(t - 11'(PAT_W));
         else
            pos_d = t[9:0];
      end
   end

   logic [9:0]  r;
   logic [10:0] hsum;
   logic [10:0] c;
   logic [15:0] psum;
   logic        in_band;
   logic        pix_d;
   logic        bg_q;

   always_comb begin
      r       = gs.v_cnt - 10'(GROUND_Y);
      hsum    = 11'(gs.h_cnt) + 11'(pos_q);
      c       = hsum % 11'(PAT_W);
      psum    = 16'(c) + 16'(r) * 16'd23;
      in_band = ({1'b0, gs.v_cnt} >= 11'(GROUND_Y)) &&
                ({1'b0, gs.v_cnt} < 11'(GROUND_Y + PAT_H)) &&
                ({1'b0, gs.h_cnt} < 11'(H_ACTIVE));
      pix_d   = 1'b0;
      if (in_band) begin
         if (r == 10'd0)
            pix_d = 1'b1;
         else if (r == 10'd1)
            pix_d = 1'b0;
         else
            pix_d = (psum % 16'd53) < 16'd3;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_q <= '0;
         bg_q  <= 1'b0;
      end else begin
         pos_q <= pos_d;
         bg_q  <= pix_d;
      end
   end

   assign gs.black_ground = bg_q;
   assign gs.scroll_pos   = pos_q;
   assign gs.speed        = spd_cur;

endmodule

// File: tb/tb_ground_scroller.sv
// tb_ground_scroller: directed stimulus with a scoreboard queue and monitor.
// Expectations adapt to whether GROUND_SPEED_RAMP_EN is defined.
module tb_ground_scroller;

`ifdef GROUND_SPEED_RAMP_EN
   localparam bit RAMP = 1'b1;
`else
   localparam bit RAMP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   ground_scroller_if #(.SPD_W(4)) gs ();

   ground_scroller #(
      .PAT_W(160), .PAT_H(8), .GROUND_Y(400), .H_ACTIVE(640),
      .SPEED_INIT(6), .SPEED_MAX(12), .RAMP_FRAMES(600), .SPD_W(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .gs(gs.slave)
   );

   int    kq[$];
   int    vq[$];
   string nq[$];
   int    checks = 0;
   int    errors = 0;

   task automatic push_exp(input int k, input int v, input string n);
      kq.push_back(k);
      vq.push_back(v);
      nq.push_back(n);
   endtask

   // monitor: outputs are valid #1 after each rising edge
   initial begin
      int    k;
      int    v;
      int    act;
      string n;
      forever begin
         @(posedge clk);
         #1;
         while (kq.size() > 0) begin
            k = kq.pop_front();
            v = vq.pop_front();
            n = nq.pop_front();
            if (k == 0)      act = int'(gs.black_ground);
            else if (k == 1) act = int'(gs.scroll_pos);
            else             act = int'(gs.speed);
            checks++;
            if (act != v) begin
               errors++;
               $display("FAIL %s: got %0d, want %0d", n, act, v);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      errors++;
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $fatal(1, "timeout");
   end

   task automatic cyc(input logic r, input logic [1:0] st,
                      input logic nf, input int h, input int v);
      @(negedge clk);
      rst          = r;
      gs.state     = st;
      gs.new_frame = nf;
      gs.h_cnt     = 10'(h);
      gs.v_cnt     = 10'(v);
   endtask

   task automatic pulses(input int n, input logic [1:0] st);
      repeat (n) begin
         cyc(1'b0, st, 1'b1, 0, 0);
         cyc(1'b0, st, 1'b0, 0, 0);
      end
   endtask

   typedef struct {
      int h;
      int v;
      int e;
   } pix_t;

   pix_t ptab[10];

   initial begin
      ptab[0] = '{5, 400, 1};
      ptab[1] = '{5, 399, 0};
      ptab[2] = '{5, 401, 0};
      ptab[3] = '{5, 408, 0};
      ptab[4] = '{640, 400, 0};
      ptab[5] = '{7, 402, 1};
      ptab[6] = '{10, 402, 0};
      ptab[7] = '{0, 407, 1};
      ptab[8] = '{1, 407, 0};
      ptab[9] = '{639, 400, 1};

      gs.state     = 2'b00;
      gs.new_frame = 1'b0;
      gs.h_cnt     = '0;
      gs.v_cnt     = '0;

      cyc(1'b1, 2'b00, 1'b0, 0, 0);
      cyc(1'b1, 2'b00, 1'b0, 5, 400);
      push_exp(0, 0, "reset bg");
      push_exp(1, 0, "reset pos");
      push_exp(2, 6, "reset speed");

      cyc(1'b0, 2'b01, 1'b0, 0, 0);
      for (int i = 1; i <= 27; i++) begin
         cyc(1'b0, 2'b01, 1'b1, 0, 0);
         if (i == 26) push_exp(1, 156, "pos 26th");
         if (i == 27) push_exp(1, 2, "pos wrap 27th");
         push_exp(2, 6, "speed run");
         cyc(1'b0, 2'b01, 1'b0, 0, 0);
      end

      cyc(1'b0, 2'b01, 1'b0, 5, 402);
      push_exp(0, 1, "pix scrolled h5");
      cyc(1'b0, 2'b01, 1'b0, 8, 402);
      push_exp(0, 0, "pix scrolled h8");

      cyc(1'b1, 2'b00, 1'b0, 0, 0);
      push_exp(1, 0, "rst pos");
      for (int i = 0; i < 10; i++) begin
         cyc(1'b0, 2'b00, 1'b0, ptab[i].h, ptab[i].v);
         push_exp(0, ptab[i].e,
                  $sformatf("pix h%0d v%0d", ptab[i].h, ptab[i].v));
      end
      cyc(1'b0, 2'b00, 1'b0, 5, 400);
      cyc(1'b1, 2'b00, 1'b0, 5, 400);
      push_exp(0, 0, "rst blanks bg");

      cyc(1'b0, 2'b01, 1'b0, 0, 0);
      pulses(599, 2'b01);
      cyc(1'b0, 2'b01, 1'b1, 0, 0);
      push_exp(2, RAMP ? 7 : 6, "speed 600");
      push_exp(1, 80, "pos 600");
      cyc(1'b0, 2'b01, 1'b0, 0, 0);
      cyc(1'b0, 2'b01, 1'b1, 0, 0);
      push_exp(1, RAMP ? 87 : 86, "pos 601");
      cyc(1'b0, 2'b01, 1'b0, 0, 0);
      pulses(5399, 2'b10);
      push_exp(2, RAMP ? 12 : 6, "speed 6000");
      push_exp(1, RAMP ? 40 : 0, "pos 6000");

      pulses(50, 2'b11);
      push_exp(1, RAMP ? 40 : 0, "halt pos");
      push_exp(2, RAMP ? 12 : 6, "halt speed");

      cyc(1'b0, 2'b00, 1'b0, 0, 0);
      push_exp(2, 6, "idle speed");
      push_exp(1, RAMP ? 40 : 0, "idle pos kept");
      cyc(1'b0, 2'b00, 1'b1, 0, 0);
      push_exp(1, RAMP ? 40 : 0, "idle frame no move");
      cyc(1'b0, 2'b01, 1'b1, 0, 0);
      push_exp(1, RAMP ? 46 : 6, "restart step");
      cyc(1'b0, 2'b01, 1'b0, 0, 0);

      cyc(1'b1, 2'b01, 1'b1, 0, 0);
      push_exp(1, 0, "rst with frame pos");
      push_exp(2, 6, "rst with frame speed");

      pulses(2000, 2'b01);
      push_exp(1, 0, "pos 2000");
      push_exp(2, RAMP ? 9 : 6, "speed 2000");

      cyc(1'b0, 2'b00, 1'b0, 0, 0);
      cyc(1'b0, 2'b00, 1'b0, 0, 0);
      cyc(1'b0, 2'b00, 1'b0, 0, 0);
      if (kq.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending, want 0", kq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
